// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes and arbiter FSM states.
// Imported by alu_core and alu_arbiter.
package alu_pkg;

  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_PASS = 4'd2;
  localparam logic [3:0] FUNC_NOT  = 4'd3;
  localparam logic [3:0] FUNC_AND  = 4'd4;
  localparam logic [3:0] FUNC_OR   = 4'd5;
  localparam logic [3:0] FUNC_NAND = 4'd6;
  localparam logic [3:0] FUNC_NOR  = 4'd7;
  localparam logic [3:0] FUNC_XOR  = 4'd8;
  localparam logic [3:0] FUNC_XNOR = 4'd9;
  localparam logic [3:0] FUNC_SHL  = 4'd10;
  localparam logic [3:0] FUNC_SHR  = 4'd11;
  localparam logic [3:0] FUNC_ASHL = 4'd12;
  localparam logic [3:0] FUNC_ASHR = 4'd13;
  localparam logic [3:0] FUNC_NEG  = 4'd14;
  localparam logic [3:0] FUNC_ZERO = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational 16-op ALU.
// Overflow is only meaningful for add and sub.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            FuncCode,
  output logic [DATA_WIDTH-1:0] C,
  output logic                  OverflowFlag
);

  localparam int MSB = DATA_WIDTH - 1;

  // Decode the function code into result and overflow.
  always_comb begin
    C            = '0;
    OverflowFlag = 1'b0;
    unique case (FuncCode)
      FUNC_ADD: begin
        C = A + B;
        OverflowFlag = (A[MSB] == B[MSB]) &&
                       (C[MSB] != A[MSB]);
      end
      FUNC_SUB: begin
        C = A - B;
        OverflowFlag = (A[MSB] != B[MSB]) &&
                       (C[MSB] != A[MSB]);
      end
      FUNC_PASS: C = A;
      FUNC_NOT:  C = ~A;
      FUNC_AND:  C = A & B;
      FUNC_OR:   C = A | B;
      FUNC_NAND: C = ~(A & B);
      FUNC_NOR:  C = ~(A | B);
      FUNC_XOR:  C = A ^ B;
      FUNC_XNOR: C = ~(A ^ B);
      FUNC_SHL:  C = {A[MSB-1:0], 1'b0};
      FUNC_SHR:  C = {1'b0, A[MSB:1]};
      FUNC_ASHL: C = {A[MSB-1:0], 1'b0};
      FUNC_ASHR: C = {A[MSB], A[MSB:1]};
      FUNC_NEG:  C = '0 - A;
      FUNC_ZERO: C = '0;
      default:   C = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu_core
// between two valid/ready requesters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a0,
  input  logic [DATA_WIDTH-1:0] req_b0,
  input  logic [DATA_WIDTH-1:0] req_a1,
  input  logic [DATA_WIDTH-1:0] req_b1,
  input  logic [3:0]            req_func0,
  input  logic [3:0]            req_func1,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_c,
  output logic                  rsp_ovf,
  output logic                  busy
);

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   gid_q, gid_d;
  logic   gnt;

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [3:0]            func_q, func_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] alu_c;
  logic                  alu_ovf;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .A           (a_q),
    .B           (b_q),
    .FuncCode    (func_q),
    .C           (alu_c),
    .OverflowFlag(alu_ovf)
  );

  // Pick a requester; priority bit breaks ties.
  always_comb begin
    gnt = 1'b0;
    unique case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = prio_q;
      default: gnt = 1'b0;
    endcase
  end

  // Next-state, operand capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    gid_d     = gid_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[gnt] = 1'b1;
          a_d     = gnt ? req_a1 : req_a0;
          b_d     = gnt ? req_b1 : req_b0;
          func_d  = gnt ? req_func1 : req_func0;
          gid_d   = gnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        c_d     = alu_c;
        ovf_d   = alu_ovf;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[gid_q] = 1'b1;
        if (rsp_ready[gid_q]) begin
          prio_d  = ~gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_c   = c_q;
  assign rsp_ovf = ovf_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter
// against an arithmetic reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_func0, req_func1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_c;
  logic        rsp_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int tb_prio = 0;

  alu_arbiter #(
    .DATA_WIDTH(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a0   (req_a0),
    .req_b0   (req_b0),
    .req_a1   (req_a1),
    .req_b1   (req_b1),
    .req_func0(req_func0),
    .req_func1(req_func1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_c    (rsp_c),
    .rsp_ovf  (rsp_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic, result mod 2^16.
  function automatic logic [16:0] model(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [3:0]  f
  );
    int sa, sb, r;
    logic ov;
    logic [15:0] c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 0;
    ov = 1'b0;
    c  = 16'h0;
    case (f)
      4'd0: begin
        r = sa + sb;
        ov = (r > 32767) || (r < -32768);
        c = r[15:0];
      end
      4'd1: begin
        r = sa - sb;
        ov = (r > 32767) || (r < -32768);
        c = r[15:0];
      end
      4'd2:  c = a;
      4'd3:  c = ~a;
      4'd4:  c = a & b;
      4'd5:  c = a | b;
      4'd6:  c = ~(a & b);
      4'd7:  c = ~(a | b);
      4'd8:  c = a ^ b;
      4'd9:  c = ~(a ^ b);
      4'd10, 4'd12: begin
        r = int'(a) * 2;
        c = r[15:0];
      end
      4'd11: begin
        r = int'(a) / 2;
        c = r[15:0];
      end
      4'd13: begin
        r = (sa < 0) ? -((1 - sa) / 2) : sa / 2;
        c = r[15:0];
      end
      4'd14: begin
        r = -sa;
        c = r[15:0];
      end
      default: c = 16'h0;
    endcase
    return {ov, c};
  endfunction

  function automatic logic [1:0] oh(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_op(input int r,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [3:0]  f);
    if (r == 0) begin
      req_a0 = a; req_b0 = b; req_func0 = f;
    end else begin
      req_a1 = a; req_b1 = b; req_func1 = f;
    end
  endtask

  function automatic logic [16:0] exp_of(input int g);
    if (g == 1) return model(req_a1, req_b1, req_func1);
    return model(req_a0, req_b0, req_func0);
  endfunction

  // One full transaction with bp cycles of backpressure.
  task automatic txn(input logic [1:0] vld, input int bp);
    int g;
    logic [16:0] e;
    g = (vld == 2'b11) ? tb_prio : (vld[1] ? 1 : 0);
    e = exp_of(g);
    @(posedge clk); #1;
    req_valid = vld;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'(oh(g)));
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_rspv", 32'(rsp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    for (int i = 0; i <= bp; i++) begin
      @(posedge clk); #1;
      rsp_ready = (i == bp) ? oh(g) : oh(1 - g);
      req_valid = vld;
      @(negedge clk);
      chk("resp_rspv", 32'(rsp_valid), 32'(oh(g)));
      chk("resp_c", 32'(rsp_c), 32'(e[15:0]));
      chk("resp_ovf", 32'(rsp_ovf), 32'(e[16]));
      chk("resp_ready", 32'(req_ready), 32'd0);
      chk("resp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    @(negedge clk);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rspv", 32'(rsp_valid), 32'd0);
    tb_prio = 1 - g;
  endtask

  initial begin
    int g;
    logic [16:0] e;
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    set_op(0, 16'h0, 16'h0, 4'd0);
    set_op(1, 16'h0, 16'h0, 4'd0);

    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c", 32'(rsp_c), 32'd0);
    chk("rst_ovf", 32'(rsp_ovf), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    set_op(0, 16'h0003, 16'h0004, 4'd0);
    txn(2'b01, 0);
    set_op(1, 16'h7FFF, 16'h0001, 4'd0);
    txn(2'b10, 0);
    set_op(1, 16'h8000, 16'h0001, 4'd1);
    txn(2'b10, 0);
    set_op(0, 16'h8004, 16'h0000, 4'd13);
    txn(2'b01, 0);
    set_op(0, 16'h8004, 16'h0000, 4'd11);
    txn(2'b01, 0);
    set_op(0, 16'h0001, 16'h0000, 4'd14);
    txn(2'b01, 0);
    set_op(0, 16'h1234, 16'h00FF, 4'd8);
    txn(2'b01, 5);

    // Contention: both valid, responses always accepted.
    set_op(0, 16'($urandom), 16'($urandom), 4'($urandom));
    set_op(1, 16'($urandom), 16'($urandom), 4'($urandom));
    g = tb_prio;
    @(posedge clk); #1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_ready", 32'(req_ready), 32'(oh(g)));
      e = exp_of(g);
      @(posedge clk); #1;
      set_op(g, 16'($urandom), 16'($urandom), 4'($urandom));
      @(negedge clk);
      chk("cont_exec", 32'(req_ready | rsp_valid), 32'd0);
      @(negedge clk);
      chk("cont_rspv", 32'(rsp_valid), 32'(oh(g)));
      chk("cont_c", 32'(rsp_c), 32'(e[15:0]));
      chk("cont_ovf", 32'(rsp_ovf), 32'(e[16]));
      g = 1 - g;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tb_prio = g;

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      set_op(0, 16'($urandom), 16'($urandom), 4'($urandom));
      set_op(1, 16'($urandom), 16'($urandom), 4'($urandom));
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 3));
    end

    // Reset in EXEC: drop op, priority back to 0.
    set_op(0, 16'h0010, 16'h0020, 4'd0);
    txn(2'b01, 0);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rspv", 32'(rsp_valid), 32'd0);
    chk("arst_c", 32'(rsp_c), 32'd0);
    chk("arst_ovf", 32'(rsp_ovf), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tb_prio = 0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_rspv", 32'(rsp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    set_op(0, 16'h0005, 16'h0002, 4'd1);
    set_op(1, 16'h0009, 16'h0001, 4'd0);
    txn(2'b11, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
